// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Serial pattern scanner with a start/abort controlled frame. A frame is
//   launched from IDLE by start. It then accepts frame_len serial bits through
//   a valid/ready handshake. Each time the last PAT_W accepted bits equal the
//   latched pattern, the block counts one match, and overlapping matches count.
//
// Ports
//   clock, nreset           rising-edge clock, asynchronous active-low reset
//   start, abort            frame request (IDLE only) / cancel (SCAN only)
//   pattern [PAT_W-1:0]     target pattern, MSB is the oldest serial bit
//   frame_len [7:0]         serial bits per frame, 0 allowed
//   bit_in, bit_valid       serial data and its qualifier
//   bit_ready               high exactly while scanning (== busy)
//   match                   one-cycle pulse per detected occurrence
//   match_count [CNT_W-1:0] saturating count for current / last frame
//   busy, done              frame in progress / normal completion pulse
module pattern_scan_ctrl #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [7:0]       frame_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] shreg;
  logic [7:0]       len_q;
  logic [7:0]       bitcnt;

  // Count saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + 1'b1;
  endfunction

  // ---- stage p0: combinational view of the bit being offered this cycle ----
  logic [PAT_W-1:0] window_p0;
  logic [8:0]       cnt_next_p0;
  logic             hit_p0;
  logic             last_p0;

  assign window_p0   = (shreg << 1) | PAT_W'(bit_in);
  assign cnt_next_p0 = {1'b0, bitcnt} + 9'd1;
  // A match needs a full window of bits from this frame, not leftovers.
  assign hit_p0      = (window_p0 == pat_q) && (cnt_next_p0 >= 9'(PAT_W));
  assign last_p0     = (cnt_next_p0 == {1'b0, len_q});

  // bit_ready is a pure copy of the registered busy flag, so it never
  // depends on bit_valid within the same cycle.
  assign bit_ready = busy;

  // ---- stage p1: registered FSM, datapath and outputs ----
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      match       <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
      shreg       <= '0;
      bitcnt      <= '0;
      pat_q       <= '0;
      len_q       <= '0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            len_q       <= frame_len;
            shreg       <= '0;
            bitcnt      <= '0;
            match_count <= '0;
            if (frame_len != 8'd0) begin
              state <= SCAN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          // abort wins over both acceptance and completion on the same edge
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            shreg  <= window_p0;
            bitcnt <= cnt_next_p0[7:0];
            if (hit_p0) begin
              match       <= 1'b1;
              match_count <= sat_inc(match_count);
            end
            if (last_p0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic [7:0] frame_len = 8'd0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;

  logic       bit_ready, match, busy, done;
  logic [7:0] match_count;
  logic       bit_ready2, match2, busy2, done2;
  logic [1:0] match_count2;

  pattern_scan_ctrl #(.PAT_W(3), .CNT_W(8)) dut (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .pattern(pattern), .frame_len(frame_len), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .match(match),
    .match_count(match_count), .busy(busy), .done(done)
  );

  pattern_scan_ctrl #(.PAT_W(3), .CNT_W(2)) dut2 (
    .clock(clock), .nreset(nreset), .start(start), .abort(abort),
    .pattern(pattern), .frame_len(frame_len), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready2), .match(match2),
    .match_count(match_count2), .busy(busy2), .done(done2)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // frame stimulus and observations
  bit   bits_q[$];
  int   exp_match[$];
  int   obs_match[$];
  int   obs_done, obs_done_at, obs_busy, hs_err, obs_match2;
  bit   done_with_match;
  logic [7:0] obs_count;
  logic [1:0] obs_count2;

  // Reference: a match ends at bit k when bits k-2..k, oldest first, read as
  // a binary number equal the pattern. Only bits 1..limit count.
  function automatic void build_exp(input logic [2:0] pat, input int limit);
    exp_match.delete();
    for (int k = 3; k <= limit; k++) begin
      int v;
      v = 4 * int'(bits_q[k-3]) + 2 * int'(bits_q[k-2]) + int'(bits_q[k-1]);
      if (v == int'(pat)) exp_match.push_back(k);
    end
  endfunction

  function automatic bit same_match_list();
    if (obs_match.size() != exp_match.size()) return 1'b0;
    foreach (exp_match[i]) if (obs_match[i] != exp_match[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Runs one frame. gap>=0: fixed idle cycles between bits, gap<0: random.
  // abort_after>=0: abort raised once that many bits have been accepted.
  task automatic drive_frame(input logic [2:0] pat, input int len, input int gap,
                             input int abort_after);
    bit scan, prev_acc, ab;
    int acc, idle_left, tail;
    bit finished;
    obs_match.delete();
    obs_done = 0; obs_done_at = -1; obs_busy = 0; hs_err = 0; obs_match2 = 0;
    done_with_match = 1'b0;
    @(negedge clock);
    start = 1'b1; pattern = pat; frame_len = len[7:0];
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    pattern = 3'($urandom); frame_len = 8'($urandom);
    scan = (len != 0); prev_acc = 1'b0; acc = 0; idle_left = 0; tail = 2;
    finished = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (match) obs_match.push_back(prev_acc ? acc : -1);
      if (match2) obs_match2++;
      if (done) begin
        obs_done++; obs_done_at = acc; done_with_match = match;
      end
      if (busy !== scan || bit_ready !== scan) hs_err++;
      if (busy2 !== scan || bit_ready2 !== scan || done2 !== done) hs_err++;
      if (busy) obs_busy++;
      if (!scan) begin
        tail--;
        if (tail == 0) begin finished = 1'b1; break; end
      end
      ab = scan && (abort_after >= 0) && (acc == abort_after);
      abort = ab;
      start = scan ? ($urandom_range(0, 3) == 0) : 1'b0;
      pattern = 3'($urandom); frame_len = 8'($urandom);
      if (!scan) begin
        bit_valid = 1'($urandom); bit_in = 1'($urandom);
      end else if (idle_left > 0) begin
        bit_valid = 1'b0; bit_in = 1'($urandom); idle_left--;
      end else begin
        bit_valid = 1'b1; bit_in = bits_q[acc];
      end
      @(posedge clock);
      prev_acc = scan && bit_valid && !ab;
      if (prev_acc) begin
        acc++;
        idle_left = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (acc == len) scan = 1'b0;
      end
      if (ab) scan = 1'b0;
      @(negedge clock);
    end
    if (!finished) hs_err++;
    abort = 1'b0; bit_valid = 1'b0; start = 1'b0;
    obs_count = match_count;
    obs_count2 = match_count2;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    #12;
    tests_run++;
    if ({busy, bit_ready, match, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/ready/match/done=%b required 0000",
               {busy, bit_ready, match, done});
    end
    tests_run++;
    if (match_count !== 8'd0 || match_count2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d/%0d required 0", match_count, match_count2);
    end
    @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic load_basic_bits;
    bit b[8] = '{1, 0, 1, 0, 1, 1, 0, 1};
    bits_q.delete();
    foreach (b[i]) bits_q.push_back(b[i]);
  endtask

  task automatic test_basic;
    load_basic_bits();
    exp_match = '{3, 5, 8};
    drive_frame(3'b101, 8, 0, -1);
    tests_run++;
    if (!same_match_list()) begin
      tests_failed++;
      $display("FAIL basic_positions: got %p required %p", obs_match, exp_match);
    end
    tests_run++;
    if (obs_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d required 3", obs_count);
    end
    tests_run++;
    if (obs_done != 1 || obs_done_at != 8 || !done_with_match) begin
      tests_failed++;
      $display("FAIL basic_done: pulses %0d at bit %0d with match %0b required 1 at 8 with match",
               obs_done, obs_done_at, done_with_match);
    end
    tests_run++;
    if (hs_err != 0) begin
      tests_failed++;
      $display("FAIL basic_handshake: %0d busy/ready errors required 0", hs_err);
    end
  endtask

  task automatic test_hold;
    repeat (6) begin
      @(negedge clock);
      bit_valid = 1'($urandom); bit_in = 1'($urandom); abort = 1'($urandom);
    end
    @(negedge clock);
    bit_valid = 1'b0; abort = 1'b0;
    tests_run++;
    if (match_count !== 8'd3 || busy !== 1'b0 || match !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: count %0d busy %0b match %0b required 3 0 0",
               match_count, busy, match);
    end
  endtask

  task automatic test_gaps;
    load_basic_bits();
    exp_match = '{3, 5, 8};
    drive_frame(3'b101, 8, 2, -1);
    tests_run++;
    if (!same_match_list() || obs_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL gap_matches: got %p count %0d required %p count 3",
               obs_match, obs_count, exp_match);
    end
    tests_run++;
    if (hs_err != 0 || obs_done != 1) begin
      tests_failed++;
      $display("FAIL gap_handshake: errors %0d done %0d required 0 and 1", hs_err, obs_done);
    end
  endtask

  task automatic test_zero_len;
    bits_q.delete();
    drive_frame(3'b000, 0, 0, -1);
    tests_run++;
    if (obs_done != 1 || obs_busy != 0 || hs_err != 0) begin
      tests_failed++;
      $display("FAIL zero_len: done %0d busy cycles %0d errors %0d required 1 0 0",
               obs_done, obs_busy, hs_err);
    end
    tests_run++;
    if (obs_count !== 8'd0 || obs_match.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_len_count: count %0d matches %0d required 0 0",
               obs_count, obs_match.size());
    end
  endtask

  task automatic test_saturation;
    bits_q.delete();
    repeat (8) bits_q.push_back(1'b0);
    drive_frame(3'b000, 8, 0, -1);
    tests_run++;
    if (obs_match2 != 6 || obs_count2 !== 2'd3) begin
      tests_failed++;
      $display("FAIL saturation: pulses %0d count %0d required 6 3", obs_match2, obs_count2);
    end
    tests_run++;
    if (obs_match.size() != 6 || obs_count !== 8'd6) begin
      tests_failed++;
      $display("FAIL wide_count: pulses %0d count %0d required 6 6", obs_match.size(), obs_count);
    end
  endtask

  task automatic test_abort;
    load_basic_bits();
    exp_match = '{3};
    drive_frame(3'b101, 8, 0, 4);
    tests_run++;
    if (obs_done != 0 || obs_count !== 8'd1 || !same_match_list()) begin
      tests_failed++;
      $display("FAIL abort: done %0d count %0d matches %p required 0 1 %p",
               obs_done, obs_count, obs_match, exp_match);
    end
    // abort on the cycle that would deliver the final bit
    load_basic_bits();
    drive_frame(3'b101, 5, 0, 4);
    tests_run++;
    if (obs_done != 0 || obs_count !== 8'd1 || hs_err != 0) begin
      tests_failed++;
      $display("FAIL abort_priority: done %0d count %0d errors %0d required 0 1 0",
               obs_done, obs_count, hs_err);
    end
  endtask

  task automatic test_reset_midframe;
    int bad;
    @(negedge clock);
    start = 1'b1; pattern = 3'b101; frame_len = 8'd8;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = (i != 1);
      @(negedge clock);
    end
    bit_valid = 1'b0;
    @(posedge clock);
    #3 nreset = 1'b0;
    #1;
    tests_run++;
    if ({busy, bit_ready, match, done} !== 4'b0000 || match_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_async: flags %b count %0d required 0000 0",
               {busy, bit_ready, match, done}, match_count);
    end
    @(negedge clock);
    nreset = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = (i % 2 == 0);
      @(negedge clock);
      if (busy !== 1'b0 || match !== 1'b0 || match_count !== 8'd0) bad++;
    end
    bit_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_needs_start: %0d cycles with activity required 0", bad);
    end
    load_basic_bits();
    drive_frame(3'b101, 8, 0, -1);
    tests_run++;
    if (obs_count !== 8'd3 || obs_done != 1) begin
      tests_failed++;
      $display("FAIL reset_restart: count %0d done %0d required 3 1", obs_count, obs_done);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 25; f++) begin
      logic [2:0] pat;
      int len, ab, limit;
      pat = 3'($urandom);
      len = int'($urandom_range(0, 30));
      ab = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      bits_q.delete();
      for (int i = 0; i < len; i++) bits_q.push_back(1'($urandom_range(0, 3) != 0 ? $urandom : 1));
      limit = (ab >= 0) ? ab : len;
      build_exp(pat, limit);
      drive_frame(pat, len, -1, ab);
      tests_run++;
      if (!same_match_list() || int'(obs_count) != imin(exp_match.size(), 255) ||
          int'(obs_count2) != imin(exp_match.size(), 3) || obs_match2 != exp_match.size()) begin
        tests_failed++;
        $display("FAIL random_frame%0d: got %p count %0d/%0d required %p", f,
                 obs_match, obs_count, obs_count2, exp_match);
      end
      tests_run++;
      if (obs_done != ((ab >= 0) ? 0 : 1) || hs_err != 0) begin
        tests_failed++;
        $display("FAIL random_ctrl%0d: done %0d errors %0d required %0d 0", f,
                 obs_done, hs_err, (ab >= 0) ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_gaps();
    test_zero_len();
    test_saturation();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits, legal range 1..8.
REQ-002 Parameter CNT_W, default 8: match-counter width in bits, legal range 2..16.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 nreset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a scan frame; sampled in IDLE only.
REQ-006 abort  input  1  synchronous cancel of the frame in progress.
REQ-007 pattern  input  PAT_W  target pattern; bit PAT_W-1 is the oldest serial bit.
REQ-008 frame_len  input  8  number of serial bits in the frame; 0 is legal.
REQ-009 bit_in  input  1  serial data bit.
REQ-010 bit_valid  input  1  bit_in is valid this cycle.
REQ-011 bit_ready  output  1  controller accepts a bit this cycle.
REQ-012 match  output  1  one-cycle pulse per detected pattern occurrence.
REQ-013 match_count  output  CNT_W  number of matches in the current or last frame.
REQ-014 busy  output  1  a frame is in progress.
REQ-015 done  output  1  one-cycle pulse when a frame completes normally.

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN and DONE, encoded in 2 bits; the unused code SHALL go to IDLE on the next clock.
REQ-017 In IDLE with start=1, the block SHALL latch pattern and frame_len, clear the shift register, bit counter and match_count, and enter SCAN if frame_len!=0 or DONE if frame_len==0.
REQ-018 Changes to pattern and frame_len after they are latched SHALL have no effect until the next start.
REQ-019 busy SHALL be 1 exactly in SCAN; bit_ready SHALL equal busy and SHALL NOT depend combinationally on bit_valid.
REQ-020 A bit SHALL be accepted only on a clock where bit_valid=1 and bit_ready=1; on acceptance, bit_in SHALL shift into the LSB of the shift register and the bit counter SHALL increment.
REQ-021 A match SHALL be detected when the shift window including the newly accepted bit equals the latched pattern and at least PAT_W bits have been accepted in the current frame.
REQ-022 Overlapping matches SHALL be counted (pattern 101 on the stream 10101 gives 2 matches).
REQ-023 match SHALL be registered: it is high for one cycle, on the cycle after the accepting edge; match_count SHALL update on that same edge.
REQ-024 match_count SHALL saturate at 2^CNT_W-1 with no wrap-around; match SHALL still pulse while the count is saturated.
REQ-025 When the accepted bit is bit number frame_len, the FSM SHALL go to DONE on that edge; no further bits SHALL be accepted in the frame.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE; a match from the last bit SHALL be coincident with done.
REQ-027 match_count SHALL hold its value in IDLE until the next accepted start.
REQ-028 start while not in IDLE SHALL be ignored.
REQ-029 abort=1 in SCAN SHALL go to IDLE on the next edge, with no done pulse and match_count frozen; a bit accepted on the same edge SHALL be discarded.
REQ-030 abort SHALL have priority over frame completion on the same edge, and SHALL be ignored in IDLE and DONE.
REQ-031 bit_valid gaps SHALL stall the scan without losing or altering shift-register state.

Reset
REQ-032 While nreset=0, the FSM SHALL be in IDLE and busy, bit_ready, match and done SHALL be 0.
REQ-033 While nreset=0, match_count, the shift register, the bit counter and the latched pattern and frame_len SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-035 After reset is released, the block SHALL require a new start before it accepts any bit.

Verification
REQ-036 Basic frame: PAT_W=3, pattern=101, frame_len=8, bits 1,0,1,0,1,1,0,1 sent back to back -> match after bits 3, 5 and 8; match_count=3; done coincident with the third match.
REQ-037 Handshake gaps: same stimulus as REQ-036 with bit_valid low for 2 cycles between each bit -> identical match sequence and match_count=3; bit_ready stays 1 throughout SCAN.
REQ-038 Zero-length frame: frame_len=0 -> IDLE to DONE to IDLE, done pulses once, busy never 1, match_count=0.
REQ-039 Saturation: CNT_W=2, pattern=000, frame_len=8, eight 0 bits -> 6 matches pulsed, match_count stops at 3.
REQ-040 Abort and reset: abort after bit 4 of the REQ-036 stream -> IDLE, no done, match_count=1; separately, nreset low mid-frame -> all outputs 0 immediately, and a new start is required before any bit is accepted.
